// File: rtl/i2c_pkg.sv
// Shared types and frame layout for the I2C codec configuration target.
// Optional feature macro: I2C_TARGET_READBACK_EN (adds the read-back states).
package i2c_pkg;

    localparam logic [6:0]  TARGET_ADDR_DEF = 7'h1A;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned REG_W           = 7;
    localparam int unsigned DATA_W          = 9;

    // Byte-1 layout: reg[6:0] in bits 7:1, data bit 8 in bit 0
    localparam int unsigned REG_HI  = 7;
    localparam int unsigned REG_LO  = 1;
    localparam int unsigned D8_BIT  = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_B1,
        ST_B1_ACK,
        ST_B2,
        ST_B2_ACK,
        ST_DRAIN
`ifdef I2C_TARGET_READBACK_EN
        ,
        ST_RD,
        ST_RD_ACK
`endif
    } state_e;

    function automatic logic [REG_W-1:0] frame_reg(input logic [BYTE_W-1:0] b);
        return b[REG_HI:REG_LO];
    endfunction

    function automatic logic frame_d8(input logic [BYTE_W-1:0] b);
        return b[D8_BIT];
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the system clock domain and derives
// single-cycle SCL edge and START/STOP condition pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_c_o,
    output logic scl_fall_c_o,
    output logic start_c_o,
    output logic stop_c_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchronizer chains and one history flop, preset to an idle (high) bus
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    // Edge and bus-condition pulses; START/STOP need SCL high on both samples
    always_comb begin
        scl_rise_c_o = scl_s & ~scl_hist_q;
        scl_fall_c_o = ~scl_s & scl_hist_q;
        start_c_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
        stop_c_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    end

    assign sda_o = sda_s;

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target terminating 3-byte codec register writes: address, {reg, d8}, data.
// Optional feature macro: I2C_TARGET_READBACK_EN (shadow registers + 2-byte read).
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = TARGET_ADDR_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    output logic              wr_valid,
    output logic [REG_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              addr_err
);

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .scl_i        (I2C_SCLK),
        .sda_i        (I2C_SDAT),
        .sda_o        (sda_s),
        .scl_rise_c_o (scl_rise),
        .scl_fall_c_o (scl_fall),
        .start_c_o    (start_ev),
        .stop_c_o     (stop_ev)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                ack_on_q, ack_on_d;
    logic                sda_oe_q, sda_oe_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic                d8_q, d8_d;
    logic                busy_q, busy_d;
    logic                wr_valid_q, wr_valid_d;
    logic [REG_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                addr_err_q, addr_err_d;
    logic [BYTE_W-1:0]   rx_byte;
    logic                cnt_last;
    logic                commit_c;

`ifdef I2C_TARGET_READBACK_EN
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [REG_W-1:0]  last_reg_q;
    logic              rd_q, rd_d;
    logic              rd_idx_q, rd_idx_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rd_word;
    logic [BYTE_W-1:0] rd_byte1;

    // Shadow copy of committed registers; out-of-range addresses read as zero
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) shadow_q[i] <= '0;
            last_reg_q <= '0;
        end else if (commit_c) begin
            last_reg_q <= reg_q;
            if (32'(reg_q) < NUM_REGS) shadow_q[IDX_W'(reg_q)] <= {d8_q, shift_q};
        end
    end

    // Word returned by a read of the most recently committed register
    always_comb begin
        rd_word  = (32'(last_reg_q) < NUM_REGS) ? shadow_q[IDX_W'(last_reg_q)] : '0;
        rd_byte1 = {last_reg_q, rd_word[DATA_W-1]};
    end

    // Read-path state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rd_q     <= 1'b0;
            rd_idx_q <= 1'b0;
            tx_q     <= '0;
        end else begin
            rd_q     <= rd_d;
            rd_idx_q <= rd_idx_d;
            tx_q     <= tx_d;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ack_on_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            reg_q      <= '0;
            d8_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_on_q   <= ack_on_d;
            sda_oe_q   <= sda_oe_d;
            reg_q      <= reg_d;
            d8_q       <= d8_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Frame FSM: bus conditions first, then per-state SCL edge handling
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_on_d   = ack_on_q;
        sda_oe_d   = sda_oe_q;
        reg_d      = reg_q;
        d8_d       = d8_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        addr_err_d = addr_err_q;
        commit_c   = 1'b0;
        rx_byte    = {shift_q[BYTE_W-2:0], sda_s};
        cnt_last   = (bit_cnt_q == CNT_W'(BYTE_W - 1));
`ifdef I2C_TARGET_READBACK_EN
        rd_d       = rd_q;
        rd_idx_d   = rd_idx_q;
        tx_d       = tx_q;
`endif

        if (stop_ev) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            ack_on_d = 1'b0;
        end else if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            ack_on_d  = 1'b0;
`ifdef I2C_TARGET_READBACK_EN
            rd_d      = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        if (cnt_last) begin
                            bit_cnt_d = '0;
                            if (rx_byte[7:1] == TARGET_ADDR && !rx_byte[0]) begin
                                state_d = ST_ADDR_ACK;
                            end
`ifdef I2C_TARGET_READBACK_EN
                            else if (rx_byte[7:1] == TARGET_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rd_d    = 1'b1;
                            end
`endif
                            else begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
                ST_B1, ST_B2: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        if (cnt_last) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_B1) begin
                                reg_d   = frame_reg(rx_byte);
                                d8_d    = frame_d8(rx_byte);
                                state_d = ST_B1_ACK;
                            end else begin
                                state_d = ST_B2_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_B1_ACK, ST_B2_ACK: begin
                    // First fall after bit 8 pulls SDA low; the next fall ends the ACK
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            ack_on_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_B1;
`ifdef I2C_TARGET_READBACK_EN
                                if (rd_q) begin
                                    state_d  = ST_RD;
                                    rd_idx_d = 1'b0;
                                    sda_oe_d = ~rd_byte1[BYTE_W-1];
                                    tx_d     = {rd_byte1[BYTE_W-2:0], 1'b0};
                                end
`endif
                            end else if (state_q == ST_B1_ACK) begin
                                state_d = ST_B2;
                            end else begin
                                commit_c   = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = reg_q;
                                wr_data_d  = {d8_q, shift_q};
                                if (32'(reg_q) >= NUM_REGS) addr_err_d = 1'b1;
                                state_d    = ST_DRAIN;
                            end
                        end
                    end
                end
`ifdef I2C_TARGET_READBACK_EN
                ST_RD: begin
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[BYTE_W-1];
                        tx_d     = {tx_q[BYTE_W-2:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        if (cnt_last) begin
                            bit_cnt_d = '0;
                            state_d   = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // Release for the master's ACK; only the first byte may be followed
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_s && !rd_idx_q) begin
                            state_d   = ST_RD;
                            rd_idx_d  = 1'b1;
                            bit_cnt_d = '0;
                            tx_d      = rd_word[BYTE_W-1:0];
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
`endif
                ST_IDLE, ST_DRAIN: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Open-drain data line: pulled low or left floating, never driven high
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bus-level master tasks, frame-level reference model.
// Honours I2C_TARGET_READBACK_EN for the read-back scenario.
module tb_i2c_codec_target;

    localparam int unsigned SYNC    = 2;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned T_CLK   = 20;
    localparam int unsigned Q       = 200;
    localparam longint      LAT_MAX = longint'((SYNC + 2) * T_CLK);

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       scl   = 1'b1;
    logic       m_low = 1'b0;
    wire        sda_bus;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       addr_err;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_codec_target #(
        .TARGET_ADDR (7'h1A),
        .SYNC_STAGES (SYNC),
        .NUM_REGS    (NREGS)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #(T_CLK / 2) clk = ~clk;

    int     checks      = 0;
    int     errors      = 0;
    int     wr_cnt      = 0;
    int     dut_low_cnt = 0;
    longint lat_last    = 0;
    longint t_fall      = 0;

    // Reference model state: frame-level view of committed writes
    int         m_cnt    = 0;
    logic [6:0] m_addr   = '0;
    logic [8:0] m_data   = '0;
    logic       m_err    = 1'b0;
    logic       m_commit = 1'b0;
    logic [7:0] fb [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Observe strobes and any low level on SDA not caused by the master
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            lat_last = longint'($time) - t_fall;
        end
        if (sda_bus == 1'b0 && !m_low) dut_low_cnt++;
    end

    task automatic bus_start();
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b1; #(Q);
        scl   = 1'b0; t_fall = longint'($time); #(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b0; #(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; #(Q);
        scl   = 1'b1; #(2 * Q);
        scl   = 1'b0; t_fall = longint'($time); #(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        b     = sda_bus; #(Q);
        scl   = 1'b0; t_fall = longint'($time); #(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(b);
        ack = ~b;
    endtask

`ifdef I2C_TARGET_READBACK_EN
    task automatic recv_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(~mack);
    endtask
`endif

    // START + n bytes from fb; the model predicts ACKs and any commit
    task automatic frame_body(input int n);
        logic ack;
        int   dl0;
        dl0      = dut_low_cnt;
        m_commit = 1'b0;
        bus_start();
        check("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i], ack);
            check($sformatf("ack_b%0d_%02h", i, fb[i]), 32'(ack), 32'((fb[0] == 8'h34) && (i < 3)));
        end
        if (fb[0] != 8'h34) check("no_drive", 32'(dut_low_cnt - dl0), 32'd0);
        if (fb[0] == 8'h34 && n >= 3) begin
            m_cnt++;
            m_addr   = fb[1][7:1];
            m_data   = {fb[1][0], fb[2]};
            m_commit = 1'b1;
            if (int'(m_addr) >= int'(NREGS)) m_err = 1'b1;
        end
        check("busy_pre_stop", 32'(busy), 32'd1);
    endtask

    task automatic frame_end();
        bus_stop();
        check("busy_idle", 32'(busy), 32'd0);
        check("wr_count", 32'(wr_cnt), 32'(m_cnt));
        check("wr_addr", 32'(wr_addr), 32'(m_addr));
        check("wr_data", 32'(wr_data), 32'(m_data));
        check("addr_err", 32'(addr_err), 32'(m_err));
        check("sda_released", 32'(sda_bus), 32'd1);
        if (m_commit) check("latency", 32'(lat_last <= LAT_MAX), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int n);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
        frame_body(n);
        frame_end();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic [7:0] ad;
        int         dl0;
        int         n;

        #1 rst = 1'b1;
        #(4 * T_CLK + 4);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_sda", 32'(sda_bus), 32'd1);
        #(Q); rst = 1'b0;
        #(Q);

        // Basic write: reg 7 <= 0x04D
        run_frame(8'h34, 8'h0E, 8'h4D, 8'h00, 3);
        check("basic_addr", 32'(wr_addr), 32'h07);
        check("basic_data", 32'(wr_data), 32'h04D);

        // Foreign address: never acknowledged
        run_frame(8'h40, 8'h0E, 8'h4D, 8'h00, 3);

        // STOP after byte 1 discards the frame, next frame commits
        run_frame(8'h34, 8'h12, 8'h00, 8'h00, 2);
        run_frame(8'h34, 8'h13, 8'h01, 8'h00, 3);
        check("after_abort_data", 32'(wr_data), 32'h101);

        // Repeated START mid-frame restarts the address phase
        fb[0] = 8'h34; fb[1] = 8'h12;
        frame_body(2);
        fb[0] = 8'h34; fb[1] = 8'h0A; fb[2] = 8'h5C;
        frame_body(3);
        frame_end();

        // Extra byte after the commit is NACKed
        run_frame(8'h34, 8'h00, 8'h1F, 8'hAA, 4);
        check("four_byte_data", 32'(wr_data), 32'h01F);

        // Out-of-range register: strobed, error becomes sticky
        run_frame(8'h34, 8'h40, 8'h00, 8'h00, 3);
        check("err_set", 32'(addr_err), 32'd1);
        run_frame(8'h34, 8'h02, 8'h33, 8'h00, 3);
        check("err_sticky", 32'(addr_err), 32'd1);

        // Randomized frames against the model
        for (int k = 0; k < 16; k++) begin
            fb[0] = ($urandom_range(0, 2) != 0) ? 8'h34 : 8'($urandom);
            if (fb[0] == 8'h35) fb[0] = 8'h36;
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = 8'($urandom);
            n     = int'($urandom_range(1, 4));
            frame_body(n);
            frame_end();
        end

`ifdef I2C_TARGET_READBACK_EN
        // Read back the last committed register
        run_frame(8'h34, 8'h08, 8'h11, 8'h00, 3);
        bus_start();
        send_byte(8'h35, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        recv_byte(rb, 1'b1);
        check("rd_byte1", 32'(rb), 32'h08);
        recv_byte(rb, 1'b0);
        check("rd_byte2", 32'(rb), 32'h11);
        bus_stop();
        check("rd_busy_idle", 32'(busy), 32'd0);
        check("rd_wr_count", 32'(wr_cnt), 32'(m_cnt));
`else
        // Read address is not acknowledged
        dl0 = dut_low_cnt;
        bus_start();
        send_byte(8'h35, ack);
        check("rd_nack", 32'(ack), 32'd0);
        check("rd_no_drive", 32'(dut_low_cnt - dl0), 32'd0);
        bus_stop();
        check("rd_busy_idle", 32'(busy), 32'd0);
`endif

        // Reset while the target is holding the address ACK low
        ad = 8'h34;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(ad[i]);
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        check("ack_pre_reset", 32'(sda_bus), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_sda", 32'(sda_bus), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(addr_err), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_valid", 32'(wr_valid), 32'd0);
        #(Q - 1);
        scl = 1'b0; t_fall = longint'($time); #(Q);
        rst = 1'b0; #(Q);
        bus_stop();
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;

        // Normal operation after reset
        run_frame(8'h34, 8'h0E, 8'h4D, 8'h00, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
